// File: rtl/dmem_responder_pkg.sv
// Shared types and widths for the data-memory responder.
package dmem_responder_pkg;

  localparam int unsigned DataWidth = 32;
  localparam int unsigned BeWidth   = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with byte-enable write and registered read data.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int unsigned AddrWidth = 10
) (
  input  logic                 clk_i,
  input  logic                 en_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [BeWidth-1:0]   be_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] mem_q [2**AddrWidth];
  logic [DataWidth-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < int'(BeWidth); i++) begin
          if (be_i[i]) begin
            mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side load/store responder: req/gnt accept, WAIT_CYCLES wait states, one rvalid strobe.
// Define DMEM_ERR_EN to flag misaligned or out-of-range addresses instead of aliasing.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 we_q;
  logic [31:0]          addr_q;
  logic [DataWidth-1:0] wdata_q;
  logic [BeWidth-1:0]   be_q;
  logic                 rsp_err_q, rsp_read_q;
  logic                 commit, addr_err, in_idle;
  logic                 sel_we;
  logic [31:0]          sel_addr;
  logic [DataWidth-1:0] sel_wdata, ram_rdata;
  logic [BeWidth-1:0]   sel_be;

  // With zero wait states the commit edge is the grant edge, so use live inputs in IDLE.
  assign in_idle   = (state_q == StIdle);
  assign sel_we    = in_idle ? we_i    : we_q;
  assign sel_addr  = in_idle ? addr_i  : addr_q;
  assign sel_wdata = in_idle ? wdata_i : wdata_q;
  assign sel_be    = in_idle ? be_i    : be_q;

`ifdef DMEM_ERR_EN
  assign addr_err = (sel_addr[1:0] != 2'b00) || ((sel_addr >> (ADDR_WIDTH + 2)) != 32'd0);
`else
  logic unused_addr;
  assign addr_err    = 1'b0;
  assign unused_addr = ^sel_addr;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_o   = 1'b0;
    unique case (state_q)
      StIdle: begin
        gnt_o = req_i;
        if (req_i) begin
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? StResp : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign commit = (state_d == StResp) && (state_q != StResp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= '0;
      be_q       <= '0;
      rsp_err_q  <= 1'b0;
      rsp_read_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (in_idle && req_i) begin
        we_q    <= we_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        be_q    <= be_i;
      end
      if (commit) begin
        rsp_err_q  <= addr_err;
        rsp_read_q <= !sel_we && !addr_err;
      end
    end
  end

  dmem_array #(
    .AddrWidth(ADDR_WIDTH)
  ) u_dmem_array (
    .clk_i  (clk),
    .en_i   (commit && !addr_err),
    .we_i   (sel_we),
    .addr_i (sel_addr[ADDR_WIDTH+1:2]),
    .wdata_i(sel_wdata),
    .be_i   (sel_be),
    .rdata_o(ram_rdata)
  );

  assign rvalid_o = (state_q == StResp);
  assign rdata_o  = (rvalid_o && rsp_read_q) ? ram_rdata : 32'd0;
  assign err_o    = rvalid_o && rsp_err_q;

endmodule
